// File: rtl/led_serial_tx_if.sv
// Parallel-write / LED-chain bundle for led_serial_tx.
// The master writes words; the slave drives the 595-style serial chain.
interface led_serial_tx_if #(
    parameter int WIDTH = 16
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             pend;
    logic             led_sclk;
    logic             led_sdat;
    logic             led_lat;

    modport master (
        output wr_en,
        output wr_data,
        input  busy,
        input  done,
        input  pend,
        input  led_sclk,
        input  led_sdat,
        input  led_lat
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output busy,
        output done,
        output pend,
        output led_sclk,
        output led_sdat,
        output led_lat
    );
endinterface

// File: rtl/led_serial_tx.sv
// LED bank serialiser: shifts a word MSB-first into a 74HC595-style chain,
// then pulses the latch; a one-deep pending slot absorbs writes mid-frame.
module led_serial_tx #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    led_serial_tx_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_n;
    logic [BIT_W-1:0] r_bit;
    logic [BIT_W-1:0] w_bit_n;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_n;
    logic [WIDTH-1:0] r_pdata;
    logic [WIDTH-1:0] w_pdata_n;
    logic             r_pend;
    logic             w_pend_n;

    logic r_busy;
    logic r_done;
    logic r_sclk;
    logic r_sdat;
    logic r_lat;

    logic w_div_end;
    logic w_can_launch;
    logic w_from_pend;
    logic w_from_wr;

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_pdata_n = r_pdata;
        w_pend_n  = r_pend;

        w_div_end    = (r_div == DIV_LAST);
        w_can_launch = (r_state == S_IDLE) || (r_state == S_DONE);
        w_from_pend  = w_can_launch && r_pend;
        w_from_wr    = w_can_launch && !r_pend && bus.wr_en;

        unique case (r_state)
            S_IDLE: begin
                w_state_n = S_IDLE;
            end
            S_SHIFT_LO: begin
                if (w_div_end) begin
                    w_div_n   = '0;
                    w_state_n = S_SHIFT_HI;
                end else begin
                    w_div_n = r_div + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_end) begin
                    w_div_n = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_n = S_LATCH;
                    end else begin
                        w_shift_n = {r_shift[WIDTH-2:0], 1'b0};
                        w_bit_n   = r_bit + 1'b1;
                        w_state_n = S_SHIFT_LO;
                    end
                end else begin
                    w_div_n = r_div + 1'b1;
                end
            end
            S_LATCH: begin
                if (w_div_end) begin
                    w_div_n   = '0;
                    w_state_n = S_DONE;
                end else begin
                    w_div_n = r_div + 1'b1;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // DONE relaunches straight into SHIFT_LO so back-to-back frames have no gap
        if (w_from_pend || w_from_wr) begin
            w_state_n = S_SHIFT_LO;
            w_div_n   = '0;
            w_bit_n   = '0;
            w_shift_n = w_from_pend ? r_pdata : bus.wr_data;
        end

        if (w_from_pend) begin
            w_pend_n = 1'b0;
        end
        if (bus.wr_en && !w_from_wr) begin
            w_pend_n  = 1'b1;
            w_pdata_n = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_pdata <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdat  <= 1'b0;
            r_lat   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_pdata <= w_pdata_n;
            r_pend  <= w_pend_n;
            r_busy  <= (w_state_n != S_IDLE);
            r_done  <= (w_state_n == S_DONE);
            r_sclk  <= (w_state_n == S_SHIFT_HI);
            r_lat   <= (w_state_n == S_LATCH);
            r_sdat  <= ((w_state_n == S_SHIFT_LO) ||
                        (w_state_n == S_SHIFT_HI)) ?
                       w_shift_n[WIDTH-1] : 1'b0;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pend     = r_pend;
    assign bus.led_sclk = r_sclk;
    assign bus.led_sdat = r_sdat;
    assign bus.led_lat  = r_lat;
endmodule

// File: tb/tb_led_serial_tx.sv
// Bench for led_serial_tx: a 595-chain model observes the serial pins and
// per-scenario tasks compare latched words and frame timing.
module tb_led_serial_tx;
    localparam int W     = 16;
    localparam int D     = 4;
    localparam int FRAME = W * 2 * D + D + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_serial_tx_if #(.WIDTH(W)) lbus ();
    led_serial_tx_if #(.WIDTH(2)) sbus ();

    led_serial_tx #(.WIDTH(W), .CLK_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lbus)
    );

    led_serial_tx #(.WIDTH(2), .CLK_DIV(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0] chain   = '0;
    logic [W-1:0] storage = '0;
    logic [W-1:0] got[$];
    int           done_at[$];
    int           runs[$];

    // Observes the chain pins every negedge: 595 model plus pin-level rules
    task automatic monitor();
        int   bcnt = 0;
        int   bidx = 0;
        int   latw = 0;
        int   since = D;
        logic p_sclk = 0, p_sdat = 0, p_lat = 0, p_done = 0, p_busy = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0; bidx = 0; latw = 0; since = D;
                p_sclk = 0; p_sdat = 0; p_lat = 0; p_done = 0; p_busy = 0;
            end else begin
                since = (lbus.led_sdat !== p_sdat) ? 0 : since + 1;
                if (lbus.led_sclk && !p_sclk) begin
                    chain = {chain[W-2:0], lbus.led_sdat};
                    bcnt++;
                    vectors++;
                    if (since < D) begin
                        miscompares++;
                        $display("FAIL sdat_setup: %0d cycles, need %0d", since, D);
                    end
                end
                if (p_sclk && lbus.led_sclk) begin
                    vectors++;
                    if (lbus.led_sdat !== p_sdat) begin
                        miscompares++;
                        $display("FAIL sdat_hold: sdat %b while sclk high, was %b",
                                 lbus.led_sdat, p_sdat);
                    end
                end
                if (lbus.led_lat) begin
                    vectors++;
                    if (lbus.led_sclk !== 1'b0) begin
                        miscompares++;
                        $display("FAIL lat_sclk_overlap: sclk %b with lat high, need 0",
                                 lbus.led_sclk);
                    end
                end
                if (lbus.led_lat && !p_lat) begin
                    storage = chain;
                    got.push_back(chain);
                    vectors++;
                    if (bcnt != W) begin
                        miscompares++;
                        $display("FAIL bits_per_frame: %0d, need %0d", bcnt, W);
                    end
                    bcnt = 0;
                end
                if (lbus.led_lat) begin
                    latw++;
                end else if (p_lat) begin
                    vectors++;
                    if (latw != D) begin
                        miscompares++;
                        $display("FAIL lat_width: %0d, need %0d", latw, D);
                    end
                    latw = 0;
                end
                if (lbus.done) begin
                    vectors++;
                    if (p_done) begin
                        miscompares++;
                        $display("FAIL done_pulse: done high 2 cycles, need 1");
                    end
                end
                if (lbus.busy) bidx++;
                if (lbus.done) done_at.push_back(bidx);
                if (!lbus.busy && p_busy) runs.push_back(bidx);
                if (!lbus.busy) bidx = 0;
                p_sclk = lbus.led_sclk;
                p_sdat = lbus.led_sdat;
                p_lat  = lbus.led_lat;
                p_done = lbus.done;
                p_busy = lbus.busy;
            end
        end
    endtask

    task automatic clear_obs();
        got.delete();
        done_at.delete();
        runs.delete();
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [W-1:0] d);
        lbus.wr_en   = 1'b1;
        lbus.wr_data = d;
        @(posedge clk);
        #1;
        lbus.wr_en   = 1'b0;
        lbus.wr_data = W'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((lbus.busy || lbus.pend) && n < 4 * FRAME) begin
            cycle(1);
            n++;
        end
        vectors++;
        if (lbus.busy || lbus.pend) begin
            miscompares++;
            $display("FAIL %s_timeout: busy %b pend %b after %0d cycles, need idle",
                     tag, lbus.busy, lbus.pend, n);
        end
        cycle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lbus.wr_en = 1'b1;
        lbus.wr_data = 16'hBEEF;
        sbus.wr_en = 1'b1;
        sbus.wr_data = 2'b11;
        cycle(3);
        lbus.wr_en = 1'b0;
        sbus.wr_en = 1'b0;
        vectors++;
        if ({lbus.busy, lbus.done, lbus.pend, lbus.led_sclk,
             lbus.led_sdat, lbus.led_lat} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: %b, need 000000",
                     {lbus.busy, lbus.done, lbus.pend, lbus.led_sclk,
                      lbus.led_sdat, lbus.led_lat});
        end
        vectors++;
        if ({sbus.busy, sbus.done, sbus.pend, sbus.led_sclk,
             sbus.led_sdat, sbus.led_lat} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs_small: %b, need 000000",
                     {sbus.busy, sbus.done, sbus.pend, sbus.led_sclk,
                      sbus.led_sdat, sbus.led_lat});
        end
        rst = 1'b0;
        cycle(2);
        vectors++;
        if (lbus.busy !== 1'b0 || lbus.pend !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: busy %b pend %b, need 0 0",
                     lbus.busy, lbus.pend);
        end
    endtask

    task automatic test_single();
        clear_obs();
        write(16'hA5C3);
        vectors++;
        if (lbus.busy !== 1'b1 || lbus.led_sclk !== 1'b0) begin
            miscompares++;
            $display("FAIL launch_latency: busy %b sclk %b, need 1 0",
                     lbus.busy, lbus.led_sclk);
        end
        wait_idle("single");
        vectors++;
        if (got.size() != 1 || got[0] !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL single_word: %0d frames first %h, need 1 frame a5c3",
                     got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
        end
        vectors++;
        if (done_at.size() != 1 || done_at[0] != FRAME) begin
            miscompares++;
            $display("FAIL single_done_cycle: %0d pulses at %0d, need 1 at %0d",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, FRAME);
        end
        vectors++;
        if (runs.size() != 1 || runs[0] != FRAME) begin
            miscompares++;
            $display("FAIL single_busy_len: %0d runs len %0d, need 1 len %0d",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1, FRAME);
        end
    endtask

    task automatic test_pending();
        clear_obs();
        write(16'h0001);
        cycle(10);
        write(16'hFFFF);
        vectors++;
        if (lbus.pend !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_set: pend %b, need 1", lbus.pend);
        end
        cycle(5);
        write(16'h1234);
        wait_idle("pending");
        vectors++;
        if (got.size() != 2 || got[0] !== 16'h0001 || got[1] !== 16'h1234) begin
            miscompares++;
            $display("FAIL pend_words: %0d frames last %h, need 0001,1234",
                     got.size(), (got.size() > 0) ? got[got.size()-1] : 16'hxxxx);
        end
        vectors++;
        if (runs.size() != 1 || runs[0] != 2 * FRAME) begin
            miscompares++;
            $display("FAIL pend_no_gap: %0d runs len %0d, need 1 len %0d",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1, 2 * FRAME);
        end
        vectors++;
        if (done_at.size() != 2 || done_at[0] != FRAME || done_at[1] != 2 * FRAME) begin
            miscompares++;
            $display("FAIL pend_done_cycles: %0d pulses, need at %0d and %0d",
                     done_at.size(), FRAME, 2 * FRAME);
        end
    endtask

    task automatic test_done_write();
        int n = 0;
        clear_obs();
        write(16'h0F0F);
        while (!lbus.done && n < 2 * FRAME) begin
            cycle(1);
            n++;
        end
        vectors++;
        if (lbus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_wait_timeout: done %b, need 1", lbus.done);
        end
        write(16'h00FF);
        vectors++;
        if (lbus.busy !== 1'b1 || lbus.led_lat !== 1'b0 || lbus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_relaunch: busy %b lat %b done %b, need 1 0 0",
                     lbus.busy, lbus.led_lat, lbus.done);
        end
        wait_idle("done_write");
        vectors++;
        if (got.size() != 2 || got[0] !== 16'h0F0F || got[1] !== 16'h00FF) begin
            miscompares++;
            $display("FAIL done_write_words: %0d frames last %h, need 0f0f,00ff",
                     got.size(), (got.size() > 0) ? got[got.size()-1] : 16'hxxxx);
        end
        vectors++;
        if (runs.size() != 1 || runs[0] != 2 * FRAME) begin
            miscompares++;
            $display("FAIL done_write_gap: %0d runs len %0d, need 1 len %0d",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1, 2 * FRAME);
        end
    endtask

    task automatic test_abort();
        int   rises = 0;
        int   n = 0;
        logic prev = 1'b0;
        clear_obs();
        write(16'hFFFF);
        while (rises < 9 && n < FRAME) begin
            if (lbus.led_sclk && !prev) rises++;
            prev = lbus.led_sclk;
            if (rises < 9) cycle(1);
            n++;
        end
        rst = 1'b1;
        cycle(1);
        vectors++;
        if ({lbus.busy, lbus.done, lbus.pend, lbus.led_sclk,
             lbus.led_sdat, lbus.led_lat} !== 6'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: %b after %0d rises, need 000000",
                     {lbus.busy, lbus.done, lbus.pend, lbus.led_sclk,
                      lbus.led_sdat, lbus.led_lat}, rises);
        end
        rst = 1'b0;
        cycle(2);
        vectors++;
        if (got.size() != 0 || storage !== 16'h00FF) begin
            miscompares++;
            $display("FAIL abort_no_latch: %0d latches storage %h, need 0 00ff",
                     got.size(), storage);
        end
        write(16'h8000);
        wait_idle("abort");
        vectors++;
        if (got.size() != 1 || storage !== 16'h8000) begin
            miscompares++;
            $display("FAIL abort_recover: %0d frames storage %h, need 1 8000",
                     got.size(), storage);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            logic [W-1:0] exp[$];
            logic [W-1:0] w;
            int           k;
            clear_obs();
            w = W'($urandom);
            exp.push_back(w);
            write(w);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                cycle($urandom_range(1, 25));
                w = W'($urandom);
                write(w);
            end
            if (k > 0) exp.push_back(w);
            wait_idle("random");
            vectors++;
            if (got.size() != exp.size()) begin
                miscompares++;
                $display("FAIL random_count: %0d frames, need %0d", got.size(), exp.size());
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    vectors++;
                    if (got[i] !== exp[i]) begin
                        miscompares++;
                        $display("FAIL random_word[%0d]: %h, need %h", i, got[i], exp[i]);
                    end
                end
            end
            vectors++;
            if (runs.size() != 1 || runs[0] != FRAME * exp.size()) begin
                miscompares++;
                $display("FAIL random_busy_len: %0d runs len %0d, need 1 len %0d",
                         runs.size(), (runs.size() > 0) ? runs[0] : -1,
                         FRAME * exp.size());
            end
            cycle($urandom_range(0, 7));
        end
    endtask

    task automatic test_small();
        localparam int SW = 2;
        localparam int SD = 1;
        logic [1:0] word = 2'b10;
        logic [9:0] e_busy = '0, e_sclk = '0, e_sdat = '0, e_lat = '0, e_done = '0;
        logic [9:0] o_busy = '0, o_sclk = '0, o_sdat = '0, o_lat = '0, o_done = '0;
        int n = 0;
        for (int b = SW - 1; b >= 0; b--) begin
            for (int c = 0; c < SD; c++) begin
                e_busy[n] = 1'b1; e_sdat[n] = word[b]; n++;
            end
            for (int c = 0; c < SD; c++) begin
                e_busy[n] = 1'b1; e_sclk[n] = 1'b1; e_sdat[n] = word[b]; n++;
            end
        end
        for (int c = 0; c < SD; c++) begin
            e_busy[n] = 1'b1; e_lat[n] = 1'b1; n++;
        end
        e_busy[n] = 1'b1; e_done[n] = 1'b1; n++;
        sbus.wr_en = 1'b1;
        sbus.wr_data = word;
        cycle(1);
        sbus.wr_en = 1'b0;
        sbus.wr_data = 2'b01;
        for (int i = 0; i < 10; i++) begin
            o_busy[i] = sbus.busy;
            o_sclk[i] = sbus.led_sclk;
            o_sdat[i] = sbus.led_sdat;
            o_lat[i]  = sbus.led_lat;
            o_done[i] = sbus.done;
            cycle(1);
        end
        vectors++;
        if (o_busy !== e_busy) begin
            miscompares++;
            $display("FAIL small_busy: %b, need %b (%0d cycles)", o_busy, e_busy, n);
        end
        vectors++;
        if (o_sclk !== e_sclk) begin
            miscompares++;
            $display("FAIL small_sclk: %b, need %b", o_sclk, e_sclk);
        end
        vectors++;
        if (o_sdat !== e_sdat) begin
            miscompares++;
            $display("FAIL small_sdat: %b, need %b", o_sdat, e_sdat);
        end
        vectors++;
        if (o_lat !== e_lat) begin
            miscompares++;
            $display("FAIL small_lat: %b, need %b", o_lat, e_lat);
        end
        vectors++;
        if (o_done !== e_done) begin
            miscompares++;
            $display("FAIL small_done: %b, need %b", o_done, e_done);
        end
    endtask

    initial begin
        lbus.wr_en   = 1'b0;
        lbus.wr_data = '0;
        sbus.wr_en   = 1'b0;
        sbus.wr_data = '0;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_pending();
        test_done_write();
        test_abort();
        test_random();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end
endmodule
